// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path (and the transmit stage
// that will reuse the baud tick generator later on).
//   - rx_state_e  : receiver FSM state encoding (3 bits)
//   - OVERSAMPLE  : number of baud ticks per bit period
//   - S_A/S_B/S_C : sample index of the three mid-bit samples
//   - S_END       : last sample index of a bit period
//   - majority3() : 2-out-of-3 vote used on the mid-bit samples
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [3:0] S_A   = 4'd7;
    localparam logic [3:0] S_B   = 4'd8;
    localparam logic [3:0] S_C   = 4'd9;
    localparam logic [3:0] S_END = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Divides the system clock down to the oversampling tick rate. The counter
// is held at zero while i_clear is high, so the first tick after clear is
// released arrives exactly CLKS_PER_TICK cycles later; this is what lets
// the receiver align its sampling phase to the start edge.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous reset, active-low
//   i_clear    hold the divider cleared (no ticks while high)
//   o_tick     one-cycle pulse every CLKS_PER_TICK clocks
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_TICK = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned    CW   = $clog2(CLKS_PER_TICK) + 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and tick: the tick is decoded combinationally from the
    // terminal count so it lines up with the counter wrapping to zero.
    always_comb begin
        cnt_d  = cnt_q;
        o_tick = 1'b0;
        if (i_clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            o_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver, LSB first, 16x oversampling with a 3-sample majority
// vote at mid-bit. Feeds the UART protocol decoder directly.
// Ports:
//   i_clk             system clock, rising edge
//   i_reset_n         asynchronous reset, active-low
//   i_rx              serial line (asynchronous, idle high)
//   o_received_pulse  one cycle high when o_dat holds a new good byte
//   o_dat             last good byte, held until the next one
//   o_frame_err       one cycle high when the stop bit is sampled low
//   o_busy            high whenever the FSM is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYS_FREQ = 12_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic       o_received_pulse,
    output logic [7:0] o_dat,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CLKS_PER_TICK = SYS_FREQ / (BAUD * OVERSAMPLE);

    if (CLKS_PER_TICK < 1) begin : g_bad_clks_per_tick
        $error("uart_rx: SYS_FREQ/(BAUD*16) must be at least 1");
    end

    logic       sync1_q;
    logic       rx_s_q;
    logic       rx_q;

    rx_state_e  state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] b_q, b_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] dat_q, dat_d;
    logic       pulse_q, pulse_d;
    logic       ferr_q, ferr_d;

    logic       tick;
    logic       start_edge;
    logic       vote;

    // Two-flop synchroniser plus one delay stage for edge detection. Reset
    // to 1 so that a line held low at release still looks like a fresh
    // falling edge once it propagates through.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
            rx_q    <= rx_s_q;
        end
    end

    assign start_edge = rx_q & ~rx_s_q;

    // Held cleared in IDLE so the tick phase restarts at the start edge.
    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (state_q == ST_IDLE),
        .o_tick    (tick)
    );

    // The third sample is taken live on the s=9 tick, so the vote is valid
    // exactly on that tick.
    assign vote = majority3(samp_q[0], samp_q[1], rx_s_q);

    // Receiver next-state logic. s counts ticks within a bit and wraps
    // naturally; BREAK reuses s to count consecutive high ticks.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        shreg_d = shreg_q;
        samp_d  = samp_q;
        dat_d   = dat_q;
        pulse_d = 1'b0;
        ferr_d  = 1'b0;

        if (tick && s_q == S_A) begin
            samp_d[0] = rx_s_q;
        end
        if (tick && s_q == S_B) begin
            samp_d[1] = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                s_d = '0;
                b_d = '0;
                if (start_edge) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == S_C && vote) begin
                        state_d = ST_IDLE;
                    end else if (s_q == S_END) begin
                        state_d = ST_DATA;
                        b_d     = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == S_C) begin
                        shreg_d = {vote, shreg_q[7:1]};
                    end
                    if (s_q == S_END) begin
                        if (b_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            b_d = b_q + 3'd1;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == S_C) begin
                        if (vote) begin
                            dat_d   = shreg_q;
                            pulse_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            s_d     = '0;
                            state_d = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        s_d = '0;
                    end else if (s_q == S_END) begin
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            shreg_q <= '0;
            samp_q  <= '0;
            dat_q   <= '0;
            pulse_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shreg_q <= shreg_d;
            samp_q  <= samp_d;
            dat_q   <= dat_d;
            pulse_q <= pulse_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_received_pulse = pulse_q;
    assign o_frame_err      = ferr_q;
    assign o_dat            = dat_q;
    assign o_busy           = (state_q != ST_IDLE);

endmodule
